// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: round-robin sharing of one AES-128 core among NREQ requesters.
// One job is in flight at a time. The key and plaintext are captured at grant and held
// on the core pins until the response is accepted. A watchdog aborts a job whose core
// never reports done.
//
// state | meaning
// IDLE  | no job; grant the first valid requester at/after ptr
// LOAD  | single-cycle aes_ld strobe to the core
// WAIT  | waiting for aes_done; tmo_cnt counts toward the abort
// RESP  | result presented on rsp_*; held until rsp_ready
module aes_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int TMO_CYC = 32,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*128-1:0]    req_key,
  input  logic [NREQ*128-1:0]    req_text,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [127:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   aes_ld,
  output logic [127:0]           aes_key,
  output logic [127:0]           aes_text_in,
  input  logic                   aes_done,
  input  logic [127:0]           aes_text_out,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [7:0]     TMO_LAST = 8'(TMO_CYC - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;
  logic           grant_any;
  logic [127:0]   key_q, text_q, data_q;
  logic           err_q;
  logic [7:0]     tmo_cnt;
  logic [127:0]   sel_key, sel_text;
  logic           tmo_hit;

  assign tmo_hit     = (tmo_cnt == TMO_LAST);
  assign rsp_id      = id_q;
  assign rsp_data    = data_q;
  assign rsp_err     = err_q;
  assign aes_key     = key_q;
  assign aes_text_in = text_q;

  // Round-robin search: first valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // Pick the granted requester's key and plaintext out of the packed buses.
  always_comb begin
    sel_key  = '0;
    sel_text = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id == IDW'(k)) begin
        sel_key  = req_key[128*k +: 128];
        sel_text = req_text[128*k +: 128];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and control outputs; req_ready is held low while reset is asserted.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    aes_ld    = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (grant_any) begin
          req_ready[grant_id] = rst;
          state_nxt           = ST_LOAD;
        end
      end
      ST_LOAD: begin
        aes_ld    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (aes_done || tmo_hit) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Job datapath: capture at grant, watchdog during WAIT, result capture, pointer advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= '0;
      id_q    <= '0;
      key_q   <= '0;
      text_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            id_q   <= grant_id;
            key_q  <= sel_key;
            text_q <= sel_text;
          end
        end
        ST_LOAD: tmo_cnt <= '0;
        ST_WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          // A done arriving on the final watchdog cycle still counts as success.
          if (aes_done) begin
            data_q <= aes_text_out;
            err_q  <= 1'b0;
          end else if (tmo_hit) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) ptr <= (id_q == ID_LAST) ? '0 : id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
